// File: rtl/rr_sel_arbiter_pkg.sv
// Shared types and the round-robin search helper for rr_sel_arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // Returns {found, idx}: first set req bit searching ptr, ptr+1, ... mod N_REQ.
  function automatic logic [IDX_W:0] next_rr(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] ptr
  );
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic               found;
    logic [IDX_W-1:0]   off;
    dbl   = {req, req} >> ptr;
    rot   = dbl[N_REQ-1:0];
    found = 1'b0;
    off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = IDX_W'(i);
      end
    end
    return {found, ptr + off};
  endfunction

endpackage

// File: rtl/rr_sel_arbiter_pick.sv
// Combinational rotate/priority-find of req starting at ptr.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  assign {found, idx} = next_rr(req, ptr);

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving a 3-to-8 decoder's a/en with a forced gap.
// Define ARB_TIMEOUT_EN to bound grant length to MAX_HOLD cycles.
module rr_sel_arbiter
  import arb_pkg::*;
#(
  parameter int GAP_CYCLES = 1,
  parameter int MAX_HOLD   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             release_in,
  output logic [IDX_W-1:0] sel,
  output logic             sel_en,
  output logic             busy,
  output logic             timeout
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [3:0]       gap_q, gap_d;
  logic             sel_en_q, sel_en_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             end_norm;
  logic             hold_hit;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (state_q == IDLE) begin
      hold_d = '0;
    end else if (state_q == GRANT) begin
      hold_d = hold_q + 8'd1;
    end
  end

  assign hold_hit = (hold_q == 8'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  logic [7:0] unused_max_hold;
  assign unused_max_hold = 8'(MAX_HOLD);
  assign hold_hit = 1'b0;
`endif

  assign end_norm = release_in || !req[sel_q];

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    gap_d     = gap_q;
    sel_en_d  = sel_en_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d    = pick_idx;
          ptr_d    = pick_idx + 3'd1;
          sel_en_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (end_norm || hold_hit) begin
          sel_en_d  = 1'b0;
          gap_d     = 4'(GAP_CYCLES - 1);
          timeout_d = !end_norm;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_q == 4'd0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        sel_en_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      ptr_q     <= '0;
      gap_q     <= '0;
      sel_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      gap_q     <= gap_d;
      sel_en_q  <= sel_en_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign sel     = sel_q;
  assign sel_en  = sel_en_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed plus randomized checks of rr_sel_arbiter against a cycle model.
module tb_rr_sel_arbiter;

  localparam int GAP = 2;
  localparam int MH  = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       release_in = 1'b0;
  logic [2:0] sel;
  logic       sel_en;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: mode 0 idle, 1 granted, 2 gap
  int m_mode = 0;
  int m_ptr = 0;
  int m_sel = 0;
  int m_held = 0;
  int m_gap_left = 0;
  bit m_en = 0;
  bit m_busy = 0;
  bit m_to = 0;

  rr_sel_arbiter #(
    .GAP_CYCLES (GAP),
    .MAX_HOLD   (MH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .release_in (release_in),
    .sel        (sel),
    .sel_en     (sel_en),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [7:0] r, input bit rel, input bit rs);
    bit ended;
    bit timed;
    m_to = 1'b0;
    if (rs) begin
      m_mode = 0; m_ptr = 0; m_sel = 0;
      m_en = 0; m_busy = 0; m_held = 0; m_gap_left = 0;
    end else if (m_mode == 0) begin
      for (int k = 0; k < 8; k++) begin
        if (!m_en && r[(m_ptr + k) % 8]) begin
          m_sel = (m_ptr + k) % 8;
          m_en = 1; m_busy = 1; m_held = 1; m_mode = 1;
        end
      end
      if (m_en) m_ptr = (m_sel + 1) % 8;
    end else if (m_mode == 1) begin
      ended = rel || !r[m_sel];
      timed = TO_EN && (m_held >= MH);
      if (ended || timed) begin
        m_en = 0; m_mode = 2; m_gap_left = GAP;
        m_to = timed && !ended;
      end else begin
        m_held++;
      end
    end else begin
      m_gap_left--;
      if (m_gap_left == 0) begin
        m_mode = 0; m_busy = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("sel", 8'(sel), 8'(m_sel));
    check("sel_en", 8'(sel_en), 8'(m_en));
    check("busy", 8'(busy), 8'(m_busy));
    check("timeout", 8'(timeout), 8'(m_to));
    check("en_implies_busy", 8'(sel_en & ~busy), 8'h00);
  endtask

  task automatic cyc(input logic [7:0] r, input bit rel, input bit rs);
    @(negedge clk);
    req = r;
    release_in = rel;
    rst_n = !rs;
    @(posedge clk);
    model_step(r, rel, rs);
    #1;
    compare_all();
  endtask

  initial begin
    int n;
    int hi;
    logic [7:0] wrap_exp [4];
    logic [7:0] r;
    wrap_exp[0] = 8'd0; wrap_exp[1] = 8'd7;
    wrap_exp[2] = 8'd0; wrap_exp[3] = 8'd7;

    // reset with all requests high
    cyc(8'hFF, 0, 1);
    cyc(8'hFF, 0, 1);
    check("rst_sel", 8'(sel), 8'd0);
    check("rst_en", 8'(sel_en), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    cyc(8'h00, 0, 0);
    check("post_rst_en", 8'(sel_en), 8'd0);
    check("post_rst_busy", 8'(busy), 8'd0);

    // single request, release, gap, re-grant
    cyc(8'h04, 0, 0);
    check("single_sel", 8'(sel), 8'd2);
    check("single_en", 8'(sel_en), 8'd1);
    cyc(8'h04, 1, 0);
    check("single_rel_en", 8'(sel_en), 8'd0);
    check("single_gap_busy", 8'(busy), 8'd1);
    cyc(8'h04, 0, 0);
    check("single_gap2_busy", 8'(busy), 8'd1);
    cyc(8'h04, 0, 0);
    check("single_idle_busy", 8'(busy), 8'd0);
    check("single_idle_en", 8'(sel_en), 8'd0);
    cyc(8'h04, 0, 0);
    check("single_regrant_en", 8'(sel_en), 8'd1);
    check("single_regrant_sel", 8'(sel), 8'd2);

    // round-robin wrap between 0 and 7
    cyc(8'h81, 0, 1);
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!sel_en && n < 10) begin
        cyc(8'h81, 0, 0);
        n++;
      end
      check("wrap_en", 8'(sel_en), 8'd1);
      check("wrap_sel", 8'(sel), wrap_exp[i]);
      cyc(8'h81, 1, 0);
    end

    // request drop ends grant
    cyc(8'h00, 0, 1);
    cyc(8'h20, 0, 0);
    check("drop_sel", 8'(sel), 8'd5);
    cyc(8'h00, 0, 0);
    check("drop_en", 8'(sel_en), 8'd0);
    check("drop_busy", 8'(busy), 8'd1);
    cyc(8'h00, 0, 0);
    check("drop_gap_busy", 8'(busy), 8'd1);
    cyc(8'h00, 0, 0);
    check("drop_idle_busy", 8'(busy), 8'd0);

    // reset mid-grant
    cyc(8'h08, 0, 0);
    check("mid_sel", 8'(sel), 8'd3);
    check("mid_en", 8'(sel_en), 8'd1);
    cyc(8'h08, 0, 1);
    check("mid_rst_en", 8'(sel_en), 8'd0);
    check("mid_rst_sel", 8'(sel), 8'd0);
    check("mid_rst_busy", 8'(busy), 8'd0);
    cyc(8'h08, 0, 0);
    check("mid_regrant_sel", 8'(sel), 8'd3);
    check("mid_regrant_en", 8'(sel_en), 8'd1);

`ifdef ARB_TIMEOUT_EN
    cyc(8'h00, 0, 1);
    cyc(8'h10, 0, 0);
    hi = sel_en ? 1 : 0;
    n = 0;
    while (sel_en && n < 20) begin
      cyc(8'h10, 0, 0);
      if (sel_en) hi++;
      n++;
    end
    check("to_len", 8'(hi), 8'(MH));
    check("to_pulse", 8'(timeout), 8'd1);
    cyc(8'h10, 0, 0);
    check("to_pulse_once", 8'(timeout), 8'd0);
    n = 0;
    while (!sel_en && n < 10) begin
      cyc(8'h10, 0, 0);
      n++;
    end
    check("to_regrant", 8'(sel_en), 8'd1);
    for (int i = 0; i < MH - 1; i++) cyc(8'h10, 0, 0);
    cyc(8'h10, 1, 0);
    check("to_rel_en", 8'(sel_en), 8'd0);
    check("to_rel_quiet", 8'(timeout), 8'd0);
`endif

    // randomized traffic against the model
    cyc(8'h00, 0, 1);
    for (int i = 0; i < 400; i++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = 8'h00;
      cyc(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 60) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_sel_arbiter.md
Name: rr_sel_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 3-to-8 enable decoder.
- Watches 8 request lines and picks one requester fairly.
- Drives a registered 3-bit index plus an enable, which feed the decoder's a/en inputs and so assert exactly one one-hot select line.
- Holds the grant until released, then forces a dead cycle so two decoder outputs are never active back-to-back without a gap.

Parameters:
- GAP_CYCLES, 1, number of cycles sel_en is held low between grants (legal range 1..15).
- MAX_HOLD, 64, maximum grant length in cycles when ARB_TIMEOUT_EN is defined (legal range 2..255).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- req  in  8  request lines, bit i = requester i, level-sensitive
- release  in  1  one-cycle pulse from the granted agent ending its grant
- sel  out  3  granted index, feeds decoder a
- sel_en  out  1  grant active, feeds decoder en
- busy  out  1  high in GRANT or GAP state
- timeout  out  1  one-cycle pulse on forced release (only with ARB_TIMEOUT_EN; otherwise tied 0)

Behaviour:
- All outputs are registered. One clock domain, clk; reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at an edge):
  - state=IDLE, sel=0, sel_en=0, busy=0, timeout=0, ptr=0, gap/hold counters=0.
  - Reset mid-grant drops sel_en on that edge, with no GAP.
- ptr (3-bit) is the highest-priority index.
  - Search order: ptr, ptr+1, ..., ptr+7, modulo 8 (wrap 7->0).
- State IDLE:
  - If req!=0 at an edge, choose the first set bit in search order.
  - On that edge: sel<=winner, sel_en<=1, busy<=1, ptr<=winner+1 (mod 8), state<=GRANT.
  - Latency: req sampled at edge k gives sel_en visible after edge k (1 cycle).
  - If req==0, stay in IDLE with outputs unchanged (sel holds its last value, sel_en=0).
- State GRANT:
  - sel is stable for the whole grant.
  - End condition: release==1 OR req[sel]==0 at an edge.
  - On end: sel_en<=0, gap counter loads GAP_CYCLES-1, state<=GAP.
  - release while req[sel] is still 1 still ends the grant. The requester then re-competes and gets lowest priority.
  - release in IDLE or GAP is ignored.
- State GAP:
  - sel_en=0, busy=1.
  - Counts down; when the counter is 0 at an edge, busy<=0 and state<=IDLE.
  - Minimum spacing between grants is GAP_CYCLES+1 cycles of sel_en low: GAP_CYCLES in GAP plus 1 IDLE arbitration edge.
- req changes during GRANT or GAP do not affect sel. Only IDLE arbitrates.
- Single requester repeatedly requesting is re-granted after each gap; no starvation.
- Invariant: sel_en=1 implies state=GRANT.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on grant start and increments each GRANT cycle.
  - When it reaches MAX_HOLD-1 with no other end condition, the grant ends as on release and timeout pulses 1 for one cycle (same edge that drops sel_en).
  - If release and timeout coincide, treat it as release: timeout stays 0.
- Undefined:
  - No hold counter exists; timeout is constant 0.
  - A grant lasts until release or req drop, unbounded.

Decomposition:
- Shared package arb_pkg holds:
  - the state enum (IDLE=2'd0, GRANT=2'd1, GAP=2'd2)
  - N_REQ=8, IDX_W=3
  - a function next_rr(req, ptr) returning {found, idx}
- One sub-module is natural: rr_pick. It is combinational rotate/priority-find of req from ptr; the FSM and counters stay in the top.

Test Plan:
- Reset: rst_n=0 for 2 cycles while req=8'hFF -> sel=0, sel_en=0, busy=0 during reset and on the first edge after release.
- Single request: req=8'h04 from IDLE with ptr=0 -> sel=2, sel_en=1 after one edge. Then release pulse -> sel_en=0 next edge, busy=1 for GAP_CYCLES, then IDLE, then re-grant sel=2.
- Round-robin wrap: req=8'h81 held, release every grant -> sel sequence 0,7,0,7 with ptr wrapping 1->0 after the index-7 grant.
- Req drop: granted sel=5, deassert req[5] with no release -> sel_en falls on the next edge, then GAP of GAP_CYCLES cycles.
- Reset mid-grant: sel=3, sel_en=1, assert rst_n=0 -> next edge sel_en=0, sel=0, ptr=0, no GAP. A later req=8'h08 grants index 3 after one edge.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=8'h10 held, no release -> sel_en high exactly 4 cycles, timeout=1 on the edge that drops sel_en. Release in the same cycle as the 4th -> timeout=0.
